// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and load/store, load/store first
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic [DATA_W-1:0]   if_rdata_o,
    output logic                if_valid_o,
    input  logic                ls_req_i,
    input  logic                ls_we_i,
    input  logic [ADDR_W-1:0]   ls_addr_i,
    input  logic [DATA_W-1:0]   ls_wdata_i,
    input  logic [DATA_W/8-1:0] ls_sel_i,
    output logic [DATA_W-1:0]   ls_rdata_o,
    output logic                ls_valid_o,
    output logic                stallreq_o,
    output logic                mem_ce_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_sel_o,
    input  logic [DATA_W-1:0]   mem_rdata_i
);
    localparam int SEL_W = DATA_W / 8;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_LS = 1'b1;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        sel_d      = sel_q;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (ls_req_i) begin
                    we_d    = ls_we_i;
                    addr_d  = ls_addr_i;
                    wdata_d = ls_wdata_i;
                    sel_d   = ls_sel_i;
                    owner_d = OWNER_LS;
                    state_d = S_ISSUE;
                end else if (if_req_i) begin
                    // wdata keeps its last value; it is not driven into memory for a fetch
                    we_d    = 1'b0;
                    addr_d  = if_addr_i;
                    sel_d   = '1;
                    owner_d = OWNER_IF;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = WAIT_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    if (!we_q) begin
                        if (owner_q == OWNER_LS) begin
                            ls_rdata_d = mem_rdata_i;
                        end else begin
                            if_rdata_d = mem_rdata_i;
                        end
                    end
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            owner_q    <= OWNER_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            sel_q      <= '0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            sel_q      <= sel_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    assign mem_ce_o    = (state_q == S_ISSUE);
    assign mem_we_o    = mem_ce_o & we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_sel_o   = sel_q;

    assign if_valid_o  = (state_q == S_RESP) && (owner_q == OWNER_IF);
    assign ls_valid_o  = (state_q == S_RESP) && (owner_q == OWNER_LS);
    assign if_rdata_o  = if_rdata_q;
    assign ls_rdata_o  = ls_rdata_q;

    // Combinational so the pipeline freezes in the same cycle a request appears
    assign stallreq_o  = (if_req_i & ~if_valid_o) | (ls_req_i & ~ls_valid_o);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int W1 = 1;
    localparam int W4 = 4;

    logic        clk, rst_n;
    logic        if_req, if_valid, ls_req, ls_we, ls_valid, stallreq, mem_ce, mem_we;
    logic [31:0] if_addr, if_rdata, ls_addr, ls_wdata, ls_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  ls_sel, mem_sel;

    logic        if_req_4, if_valid_4, ls_req_4, ls_we_4, ls_valid_4, stallreq_4, mem_ce_4, mem_we_4;
    logic [31:0] if_addr_4, if_rdata_4, ls_addr_4, ls_wdata_4, ls_rdata_4, mem_addr_4, mem_wdata_4, mem_rdata_4;
    logic [3:0]  ls_sel_4, mem_sel_4;

    int          checks, failures;
    logic [31:0] ref_mem [256];
    logic [31:0] env_mem [256];
    logic        env_ready = 1'b0;
    int          env_rem, env_rem4;
    logic [7:0]  env_idx;
    logic [31:0] env_addr4;
    logic [31:0] exp_if_rdata, exp_ls_rdata;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(W1)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_valid_o(if_valid),
        .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_addr_i(ls_addr), .ls_wdata_i(ls_wdata),
        .ls_sel_i(ls_sel), .ls_rdata_o(ls_rdata), .ls_valid_o(ls_valid),
        .stallreq_o(stallreq), .mem_ce_o(mem_ce), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_sel_o(mem_sel), .mem_rdata_i(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(W4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n),
        .if_req_i(if_req_4), .if_addr_i(if_addr_4), .if_rdata_o(if_rdata_4), .if_valid_o(if_valid_4),
        .ls_req_i(ls_req_4), .ls_we_i(ls_we_4), .ls_addr_i(ls_addr_4), .ls_wdata_i(ls_wdata_4),
        .ls_sel_i(ls_sel_4), .ls_rdata_o(ls_rdata_4), .ls_valid_o(ls_valid_4),
        .stallreq_o(stallreq_4), .mem_ce_o(mem_ce_4), .mem_we_o(mem_we_4), .mem_addr_o(mem_addr_4),
        .mem_wdata_o(mem_wdata_4), .mem_sel_o(mem_sel_4), .mem_rdata_i(mem_rdata_4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    function automatic logic [31:0] init_word(int idx);
        return 32'h34011100 + 32'(idx - 4) * 32'h9E3779B9;
    endfunction

    // Memory for the WAIT_CYCLES=1 port: data is valid only in the sample cycle, noise otherwise
    always @(negedge clk) begin
        if (!rst_n) begin
            env_rem   <= 0;
            mem_rdata <= $urandom;
            if (!env_ready) begin
                for (int i = 0; i < 256; i++) env_mem[i] <= init_word(i);
                env_ready <= 1'b1;
            end
        end else begin
            if (mem_ce) begin
                env_rem <= W1;
                env_idx <= mem_addr[9:2];
                if (mem_we) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_sel[b]) env_mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end else if (env_rem != 0) begin
                env_rem <= env_rem - 1;
            end
            mem_rdata <= (!mem_ce && env_rem == 1) ? env_mem[env_idx] : $urandom;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            env_rem4    <= 0;
            mem_rdata_4 <= $urandom;
        end else begin
            if (mem_ce_4) begin
                env_rem4  <= W4;
                env_addr4 <= mem_addr_4;
            end else if (env_rem4 != 0) begin
                env_rem4 <= env_rem4 - 1;
            end
            mem_rdata_4 <= (!mem_ce_4 && env_rem4 == 1) ? (env_addr4 ^ 32'h5A5A0000) : $urandom;
        end
    end

    task automatic test_reset();
        logic [135:0] rv;
        rst_n = 1'b0;
        if_req = 1'b1;
        if_addr = 32'h44;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            rv = {mem_ce, mem_we, if_valid, ls_valid, mem_addr, mem_wdata, mem_sel, if_rdata, ls_rdata};
            checks++;
            if (rv !== 136'h0) begin
                failures++;
                $display("FAIL reset_outputs got=%h exp=0", rv);
            end
            checks++;
            if (stallreq !== 1'b1) begin
                failures++;
                $display("FAIL reset_stallreq got=%b exp=1", stallreq);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (mem_ce !== (c == 1)) begin
                failures++;
                $display("FAIL reset_release_ce c=%0d got=%b exp=%b", c, mem_ce, (c == 1));
            end
            if (c == 1) begin
                checks++;
                if (mem_addr !== 32'h44) begin
                    failures++;
                    $display("FAIL reset_release_addr got=%h exp=00000044", mem_addr);
                end
            end
            if (c == 3) begin
                exp_if_rdata = ref_mem[17];
                checks++;
                if (if_valid !== 1'b1 || if_rdata !== exp_if_rdata) begin
                    failures++;
                    $display("FAIL reset_release_fetch got=%b/%h exp=1/%h", if_valid, if_rdata, exp_if_rdata);
                end
            end
            @(posedge clk); #1;
        end
        if_req = 1'b0;
    endtask

    task automatic test_fetch();
        if_req = 1'b1;
        if_addr = 32'h10;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (stallreq !== (c != 3)) begin
                failures++;
                $display("FAIL fetch_stall c=%0d got=%b exp=%b", c, stallreq, (c != 3));
            end
            checks++;
            if (if_valid !== (c == 3) || mem_ce !== (c == 1)) begin
                failures++;
                $display("FAIL fetch_timing c=%0d got=v%b/ce%b exp=v%b/ce%b", c, if_valid, mem_ce, (c == 3), (c == 1));
            end
            if (c == 1) begin
                checks++;
                if (mem_sel !== 4'hF || mem_addr !== 32'h10 || mem_we !== 1'b0) begin
                    failures++;
                    $display("FAIL fetch_issue got=sel%h/addr%h/we%b exp=self/addr00000010/we0", mem_sel, mem_addr, mem_we);
                end
            end
            if (c == 3) begin
                exp_if_rdata = 32'h34011100;
                checks++;
                if (if_rdata !== 32'h34011100) begin
                    failures++;
                    $display("FAIL fetch_data got=%h exp=34011100", if_rdata);
                end
            end
            @(posedge clk); #1;
        end
        if_req = 1'b0;
    endtask

    task automatic test_priority();
        logic [31:0] fa;
        fa = 32'($urandom_range(0, 255)) << 2;
        if_req = 1'b1;
        if_addr = fa;
        ls_req = 1'b1;
        ls_we = 1'b0;
        ls_addr = 32'h80;
        ls_sel = 4'($urandom_range(0, 15));
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if (mem_ce !== (c == 1 || c == 5)) begin
                failures++;
                $display("FAIL prio_ce c=%0d got=%b exp=%b", c, mem_ce, (c == 1 || c == 5));
            end
            checks++;
            if (ls_valid !== (c == 3) || if_valid !== (c == 7)) begin
                failures++;
                $display("FAIL prio_valid c=%0d got=ls%b/if%b exp=ls%b/if%b", c, ls_valid, if_valid, (c == 3), (c == 7));
            end
            checks++;
            if (stallreq !== (c != 7)) begin
                failures++;
                $display("FAIL prio_stall c=%0d got=%b exp=%b", c, stallreq, (c != 7));
            end
            if (c == 1 || c == 5) begin
                checks++;
                if (mem_addr !== ((c == 1) ? 32'h80 : fa)) begin
                    failures++;
                    $display("FAIL prio_addr c=%0d got=%h exp=%h", c, mem_addr, ((c == 1) ? 32'h80 : fa));
                end
            end
            if (c == 3) begin
                exp_ls_rdata = ref_mem[32];
                checks++;
                if (ls_rdata !== exp_ls_rdata) begin
                    failures++;
                    $display("FAIL prio_load_data got=%h exp=%h", ls_rdata, exp_ls_rdata);
                end
            end
            if (c == 7) begin
                exp_if_rdata = ref_mem[fa[9:2]];
                checks++;
                if (if_rdata !== exp_if_rdata) begin
                    failures++;
                    $display("FAIL prio_fetch_data got=%h exp=%h", if_rdata, exp_if_rdata);
                end
            end
            @(posedge clk); #1;
            if (c == 3) ls_req = 1'b0;
        end
        if_req = 1'b0;
    endtask

    task automatic test_store();
        int ce_cnt = 0;
        int we_cnt = 0;
        ls_req = 1'b1;
        ls_we = 1'b1;
        ls_addr = 32'h80;
        ls_sel = 4'h3;
        ls_wdata = 32'hDEADBEEF;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            ce_cnt += int'(mem_ce);
            we_cnt += int'(mem_we);
            if (c == 1) begin
                checks++;
                if (mem_we !== 1'b1 || mem_sel !== 4'h3 || mem_wdata !== 32'hDEADBEEF) begin
                    failures++;
                    $display("FAIL store_issue got=we%b/sel%h/data%h exp=we1/sel3/datadeadbeef", mem_we, mem_sel, mem_wdata);
                end
            end
            checks++;
            if (ls_valid !== (c == 3) || ls_rdata !== exp_ls_rdata) begin
                failures++;
                $display("FAIL store_resp c=%0d got=v%b/%h exp=v%b/%h", c, ls_valid, ls_rdata, (c == 3), exp_ls_rdata);
            end
            @(posedge clk); #1;
            if (c == 3) ls_req = 1'b0;
        end
        checks++;
        if (ce_cnt != 1 || we_cnt != 1) begin
            failures++;
            $display("FAIL store_pulses got=ce%0d/we%0d exp=ce1/we1", ce_cnt, we_cnt);
        end
        ref_mem[32][15:0] = 16'hBEEF;
        ls_req = 1'b1;
        ls_we = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 3) begin
                exp_ls_rdata = ref_mem[32];
                checks++;
                if (ls_valid !== 1'b1 || ls_rdata !== exp_ls_rdata) begin
                    failures++;
                    $display("FAIL store_readback got=v%b/%h exp=v1/%h", ls_valid, ls_rdata, exp_ls_rdata);
                end
            end
            @(posedge clk); #1;
        end
        ls_req = 1'b0;
    endtask

    task automatic test_wait4();
        logic [31:0] fa;
        fa = 32'($urandom_range(0, 255)) << 2;
        if_req_4 = 1'b1;
        if_addr_4 = fa;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if (if_valid_4 !== (c == 6) || mem_ce_4 !== (c == 1) || ls_valid_4 !== 1'b0) begin
                failures++;
                $display("FAIL wait4_timing c=%0d got=v%b/ce%b/ls%b exp=v%b/ce%b/ls0", c, if_valid_4, mem_ce_4, ls_valid_4, (c == 6), (c == 1));
            end
            checks++;
            if (stallreq_4 !== (c < 6)) begin
                failures++;
                $display("FAIL wait4_stall c=%0d got=%b exp=%b", c, stallreq_4, (c < 6));
            end
            if (c == 1) begin
                checks++;
                if (mem_sel_4 !== 4'hF || mem_we_4 !== 1'b0 || mem_addr_4 !== fa || mem_wdata_4 !== 32'h0) begin
                    failures++;
                    $display("FAIL wait4_issue got=sel%h/we%b/addr%h/wd%h exp=self/we0/addr%h/wd0", mem_sel_4, mem_we_4, mem_addr_4, mem_wdata_4, fa);
                end
            end
            if (c >= 6) begin
                checks++;
                if (if_rdata_4 !== (fa ^ 32'h5A5A0000) || ls_rdata_4 !== 32'h0) begin
                    failures++;
                    $display("FAIL wait4_data c=%0d got=%h/%h exp=%h/0", c, if_rdata_4, ls_rdata_4, fa ^ 32'h5A5A0000);
                end
            end
            @(posedge clk); #1;
            if (c == 6) if_req_4 = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        logic [135:0] rv;
        logic [31:0]  fa;
        if_req = 1'b1;
        if_addr = 32'h0C0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        rv = {mem_ce, mem_we, if_valid, ls_valid, mem_addr, mem_wdata, mem_sel, if_rdata, ls_rdata};
        checks++;
        if (rv !== 136'h0) begin
            failures++;
            $display("FAIL midreset_outputs got=%h exp=0", rv);
        end
        checks++;
        if (stallreq !== 1'b1) begin
            failures++;
            $display("FAIL midreset_stall_hi got=%b exp=1", stallreq);
        end
        if_req = 1'b0;
        #1;
        checks++;
        if (stallreq !== 1'b0) begin
            failures++;
            $display("FAIL midreset_stall_lo got=%b exp=0", stallreq);
        end
        exp_if_rdata = 32'h0;
        exp_ls_rdata = 32'h0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (if_valid !== 1'b0 || mem_ce !== 1'b0) begin
                failures++;
                $display("FAIL midreset_quiet c=%0d got=v%b/ce%b exp=v0/ce0", c, if_valid, mem_ce);
            end
            @(posedge clk); #1;
        end
        fa = 32'($urandom_range(0, 255)) << 2;
        if_req = 1'b1;
        if_addr = fa;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 3) begin
                exp_if_rdata = ref_mem[fa[9:2]];
                checks++;
                if (if_valid !== 1'b1 || if_rdata !== exp_if_rdata) begin
                    failures++;
                    $display("FAIL midreset_refetch got=v%b/%h exp=v1/%h", if_valid, if_rdata, exp_if_rdata);
                end
            end
            @(posedge clk); #1;
        end
        if_req = 1'b0;
    endtask

    // Model: one transaction at a time, LS wins ties, ce at grant+1, valid at grant+W+2
    task automatic test_random();
        bit          active = 1'b0;
        bit          g_ls = 1'b0;
        bit          g_we = 1'b0;
        logic [31:0] g_addr = 32'h0;
        logic [31:0] g_wdata = 32'h0;
        logic [3:0]  g_sel = 4'h0;
        int          g_cyc = 0;
        bit          drop_if = 1'b0;
        bit          drop_ls = 1'b0;
        bit          e_ce, e_ifv, e_lsv, e_stall;
        for (int t = 0; t < 420; t++) begin
            if (drop_if) begin
                if_req = 1'b0;
                drop_if = 1'b0;
            end else if (!if_req && t < 400 && $urandom_range(0, 2) == 0) begin
                if_req = 1'b1;
                if_addr = 32'($urandom_range(0, 255)) << 2;
            end
            if (drop_ls) begin
                ls_req = 1'b0;
                drop_ls = 1'b0;
            end else if (!ls_req && t < 400 && $urandom_range(0, 3) == 0) begin
                ls_req = 1'b1;
                ls_we = 1'($urandom_range(0, 1));
                ls_addr = 32'($urandom_range(0, 255)) << 2;
                ls_wdata = $urandom;
                ls_sel = 4'($urandom_range(0, 15));
            end
            e_ce  = active && (t == g_cyc + 1);
            e_ifv = active && !g_ls && (t == g_cyc + W1 + 2);
            e_lsv = active && g_ls && (t == g_cyc + W1 + 2);
            if (e_ifv) exp_if_rdata = ref_mem[g_addr[9:2]];
            if (e_lsv && !g_we) exp_ls_rdata = ref_mem[g_addr[9:2]];
            e_stall = (if_req && !e_ifv) || (ls_req && !e_lsv);
            @(negedge clk);
            checks++;
            if (mem_ce !== e_ce || mem_we !== (e_ce && g_we) || if_valid !== e_ifv || ls_valid !== e_lsv) begin
                failures++;
                $display("FAIL rand_ctrl t=%0d got=ce%b/we%b/if%b/ls%b exp=ce%b/we%b/if%b/ls%b",
                         t, mem_ce, mem_we, if_valid, ls_valid, e_ce, e_ce && g_we, e_ifv, e_lsv);
            end
            checks++;
            if (stallreq !== e_stall) begin
                failures++;
                $display("FAIL rand_stall t=%0d got=%b exp=%b", t, stallreq, e_stall);
            end
            checks++;
            if (if_rdata !== exp_if_rdata || ls_rdata !== exp_ls_rdata) begin
                failures++;
                $display("FAIL rand_rdata t=%0d got=%h/%h exp=%h/%h", t, if_rdata, ls_rdata, exp_if_rdata, exp_ls_rdata);
            end
            if (e_ce) begin
                checks++;
                if (mem_addr !== g_addr || mem_sel !== g_sel || (g_we && mem_wdata !== g_wdata)) begin
                    failures++;
                    $display("FAIL rand_issue t=%0d got=%h/%h/%h exp=%h/%h/%h", t, mem_addr, mem_sel, mem_wdata, g_addr, g_sel, g_wdata);
                end
            end
            if (!active && (ls_req || if_req)) begin
                active = 1'b1;
                g_cyc = t;
                g_ls = ls_req;
                g_we = ls_req ? ls_we : 1'b0;
                g_addr = ls_req ? ls_addr : if_addr;
                g_wdata = ls_wdata;
                g_sel = ls_req ? ls_sel : 4'hF;
                if (g_we) begin
                    for (int b = 0; b < 4; b++)
                        if (g_sel[b]) ref_mem[g_addr[9:2]][8*b +: 8] = g_wdata[8*b +: 8];
                end
            end
            if (e_ifv) begin
                active = 1'b0;
                drop_if = 1'b1;
            end
            if (e_lsv) begin
                active = 1'b0;
                drop_ls = 1'b1;
            end
            @(posedge clk); #1;
        end
        if_req = 1'b0;
        ls_req = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        exp_if_rdata = 32'h0;
        exp_ls_rdata = 32'h0;
        rst_n = 1'b0;
        if_req = 1'b0; if_addr = 32'h0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = 32'h0; ls_wdata = 32'h0; ls_sel = 4'h0;
        if_req_4 = 1'b0; if_addr_4 = 32'h0;
        ls_req_4 = 1'b0; ls_we_4 = 1'b0; ls_addr_4 = 32'h0; ls_wdata_4 = 32'h0; ls_sel_4 = 4'h0;
        test_reset();
        test_fetch();
        test_priority();
        test_store();
        test_wait4();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single instruction/data memory port between the instruction-fetch stage and the load/store (MEM) stage of the pipelined CPU core. It registers one request at a time, drives the memory's chip-enable, address and write controls for one cycle, waits a fixed memory latency, and returns the read data with a one-cycle valid pulse to the winning requester. While any request is outstanding it raises a combinational stall request to the pipeline controller. Load/store always has priority over fetch.

## Interface
- ADDR_W, 32, byte address width of both requesters and the memory port
- DATA_W, 32, data word width (multiple of 8)
- WAIT_CYCLES, 1, cycles from the mem_ce cycle to valid mem_rdata (range 1..15)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held high until if_valid
- if_addr  in  ADDR_W  fetch byte address; stable while if_req is high
- if_rdata  out  DATA_W  fetched instruction; valid in the if_valid cycle, held afterwards
- if_valid  out  1  one-cycle completion pulse for fetch
- ls_req  in  1  load/store request; held high until ls_valid
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  ADDR_W  load/store byte address
- ls_wdata  in  DATA_W  store data
- ls_sel  in  DATA_W/8  byte enables
- ls_rdata  out  DATA_W  load data; valid in the ls_valid cycle, held afterwards
- ls_valid  out  1  one-cycle completion pulse for load/store
- stallreq  out  1  pipeline stall request (combinational)
- mem_ce  out  1  memory chip enable; one-cycle pulse per transaction
- mem_we  out  1  memory write enable; qualified by mem_ce
- mem_addr  out  ADDR_W  memory byte address
- mem_wdata  out  DATA_W  memory write data
- mem_sel  out  DATA_W/8  memory byte enables; all ones for fetch
- mem_rdata  in  DATA_W  memory read data

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE
  - If ls_req is high: latch ls_we, ls_addr, ls_wdata and ls_sel, set owner = LS, go to ISSUE.
  - Else if if_req is high: latch if_addr, set we = 0 and sel = all ones, set owner = IF, go to ISSUE.
  - Else remain in IDLE.
- ISSUE: mem_ce = 1 and the memory outputs carry the latched values. Load the counter with WAIT_CYCLES and go to WAIT.
- WAIT
  - Decrement the counter each cycle.
  - When the counter reaches 1, capture mem_rdata into the owner's rdata register (captured only for loads and fetches) and go to RESP.
- RESP: pulse the owner's valid for one cycle, then go to IDLE.
- The next arbitration happens in IDLE, so there is at least one idle cycle between transactions.
- The memory outputs hold their last latched values outside ISSUE, but mem_ce and mem_we are 0.
- If a requester drops its req before its valid pulse (a protocol violation), the transaction still completes and the valid pulse still fires. Nothing is aborted.
- stallreq = (if_req & ~if_valid) | (ls_req & ~ls_valid).
- Address and data pass through unchanged. The memory performs word indexing; the arbiter does no alignment checks.

## Timing
- Reset (rst low, asynchronous): state = IDLE, counter = 0, owner = IF. mem_ce, mem_we, mem_addr, mem_wdata, mem_sel, if_rdata, ls_rdata, if_valid and ls_valid all = 0.
- Reset mid-transaction abandons the access immediately; no valid pulse follows. stallreq follows the inputs during reset.
- Latency from the request being sampled in IDLE (cycle 0):
  - mem_ce high in cycle 1.
  - mem_rdata sampled at the end of cycle WAIT_CYCLES+1.
  - valid high in cycle WAIT_CYCLES+2.
- With WAIT_CYCLES = 1 the latency is 3 cycles; stores use the same timing.
- Throughput: one transaction per WAIT_CYCLES+3 cycles.
- Both requests sampled in the same IDLE cycle: LS is served; IF keeps stalling and is served in the next IDLE cycle if if_req is still high.
- A new ls_req arriving during an IF transaction waits for it to finish; the transaction in progress is not pre-empted.
- rdata registers change only on capture.

## Test plan
- Reset with rst = 0 for 3 cycles while if_req = 1 -> all outputs 0 and no mem_ce; after release, mem_ce rises in the second cycle.
- Single fetch, WAIT_CYCLES = 1, if_addr = 0x00000010, memory returns 0x34011100 -> mem_ce in cycle 1 with mem_sel = 0xF; if_valid in cycle 3 with if_rdata = 0x34011100; stallreq = 1 in cycles 0-2 and 0 in cycle 3.
- Simultaneous if_req and load (ls_addr = 0x80) -> load is served first with ls_valid in cycle 3; fetch mem_ce in cycle 5, if_valid in cycle 7.
- Store with ls_we = 1, ls_sel = 0x3, ls_wdata = 0xDEADBEEF -> mem_ce = mem_we = 1 for exactly one cycle with the matching sel and data; ls_valid pulses; ls_rdata unchanged.
- WAIT_CYCLES = 4: fetch -> if_valid exactly 6 cycles after sampling, and data is captured from mem_rdata in cycle 5 only.
- rst asserted during WAIT -> outputs zero immediately, no valid pulse; a new fetch after release completes normally.
